// File: rtl/guess_solver.sv
// guess_solver: binary-search guesser for the number-guessing game.
// The player answers each guess with higher / lower / correct pushbuttons; the block shows
// the guess, the attempt count and elapsed seconds on six active-low 7-segment digits.
module guess_solver #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned DEBOUNCE = 500_000,
    parameter int unsigned MIN_NUM  = 1,
    parameter int unsigned MAX_NUM  = 30
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pb_hi,
    input  logic       i_pb_lo,
    input  logic       i_pb_ok,
    output logic [6:0] o_seg0,
    output logic [6:0] o_seg1,
    output logic [6:0] o_seg2,
    output logic [6:0] o_seg3,
    output logic [6:0] o_seg4,
    output logic [6:0] o_seg5,
    output logic       o_done,
    output logic       o_cheat
);

    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DbW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);
    localparam logic [DbW-1:0]   DbMax   = DbW'(DEBOUNCE - 1);
    localparam logic [4:0]       LoInit  = 5'(MIN_NUM);
    localparam logic [4:0]       HiInit  = 5'(MAX_NUM);

    localparam logic [6:0] SegBlank = 7'b1111111;
    localparam logic [6:0] SegDash  = 7'b0111111;
    localparam logic [7:0] SecLimit = 8'h59;

    typedef enum logic [2:0] {
        StIdle,
        StGuess,
        StWin,
        StCheat,
        StTimeout
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic [4:0]       r_lo;
    logic [4:0]       r_hi;
    logic [3:0]       r_att;
    logic [7:0]       r_sec;
    logic [TickW-1:0] r_tick;
    logic             r_done;
    logic             r_cheat;

    // Button index: 0 = higher, 1 = lower, 2 = ok/start. Raw levels are active-low.
    logic [2:0] w_pb_raw;
    logic [2:0] w_ev;

    assign w_pb_raw = {i_pb_ok, i_pb_lo, i_pb_hi};

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        logic           r_s1;
        logic           r_s2;
        logic           r_db;
        logic [DbW-1:0] r_cnt;

        // Two-flop synchroniser, then accept a new level once it has been stable long enough
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_s1  <= 1'b1;
                r_s2  <= 1'b1;
                r_db  <= 1'b1;
                r_cnt <= '0;
            end else begin
                r_s1 <= w_pb_raw[gi];
                r_s2 <= r_s1;
                if (r_s2 != r_db) begin
                    if (r_cnt == DbMax) begin
                        r_db  <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        // Press pulse on the cycle the debounced level falls; release produces nothing
        assign w_ev[gi] = r_db & ~r_s2 & (r_cnt == DbMax);
    end

    // Simultaneous presses cancel each other.
    logic w_hi;
    logic w_lo;
    logic w_ok;

    assign w_hi = (w_ev == 3'b001);
    assign w_lo = (w_ev == 3'b010);
    assign w_ok = (w_ev == 3'b100);

    // Search arithmetic: the sum is kept 6 bits wide so lo+hi cannot overflow.
    logic [5:0] w_sum;
    logic [4:0] w_guess;
    logic [5:0] w_lo_new;
    logic [4:0] w_hi_new;
    logic       w_cheat_hi;
    logic       w_cheat_lo;

    assign w_sum      = {1'b0, r_lo} + {1'b0, r_hi};
    assign w_guess    = 5'(w_sum >> 1);
    assign w_lo_new   = {1'b0, w_guess} + 6'd1;
    assign w_hi_new   = w_guess - 5'd1;
    assign w_cheat_hi = (w_lo_new > {1'b0, r_hi});
    assign w_cheat_lo = (r_lo > w_hi_new);

    // Seconds timer, BCD.
    logic       w_in_guess;
    logic       w_wrap;
    logic [7:0] w_sec_inc;
    logic       w_timeout;

    assign w_in_guess = (r_state == StGuess);
    assign w_wrap     = w_in_guess && (r_tick == TickMax);
    assign w_sec_inc  = (r_sec[3:0] == 4'd9) ? {r_sec[7:4] + 4'd1, 4'd0}
                                             : {r_sec[7:4], r_sec[3:0] + 4'd1};
    assign w_timeout  = w_wrap && (r_sec != SecLimit) && (w_sec_inc == SecLimit);

    // State register plus registered status flags derived from the next state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_done  <= 1'b0;
            r_cheat <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (w_state_next == StWin);
            r_cheat <= (w_state_next == StCheat);
        end
    end

    // Next-state logic; a timeout tick overrides whatever the same-cycle press decided
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StGuess: begin
                if (w_hi) begin
                    w_state_next = w_cheat_hi ? StCheat : StGuess;
                end else if (w_lo) begin
                    w_state_next = w_cheat_lo ? StCheat : StGuess;
                end else if (w_ok) begin
                    w_state_next = StWin;
                end
                if (w_timeout) begin
                    w_state_next = StTimeout;
                end
            end
            default: begin
                if (w_ok) begin
                    w_state_next = StGuess;
                end
            end
        endcase
    end

    // Search bounds, attempt counter and timer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lo   <= LoInit;
            r_hi   <= HiInit;
            r_att  <= 4'd0;
            r_sec  <= 8'h00;
            r_tick <= '0;
        end else if (!w_in_guess) begin
            if (w_ok) begin
                r_lo   <= LoInit;
                r_hi   <= HiInit;
                r_att  <= 4'd1;
                r_sec  <= 8'h00;
                r_tick <= '0;
            end
        end else begin
            r_tick <= w_wrap ? '0 : r_tick + 1'b1;
            if (w_wrap && (r_sec != SecLimit)) begin
                r_sec <= w_sec_inc;
            end
            if (w_hi) begin
                r_lo <= w_lo_new[4:0];
                if (!w_cheat_hi && (r_att != 4'd9)) begin
                    r_att <= r_att + 4'd1;
                end
            end else if (w_lo) begin
                r_hi <= w_hi_new;
                if (!w_cheat_lo && (r_att != 4'd9)) begin
                    r_att <= r_att + 4'd1;
                end
            end
        end
    end

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'b1000000;
            4'd1:    f_seg = 7'b1111001;
            4'd2:    f_seg = 7'b0100100;
            4'd3:    f_seg = 7'b0110000;
            4'd4:    f_seg = 7'b0011001;
            4'd5:    f_seg = 7'b0010010;
            4'd6:    f_seg = 7'b0000010;
            4'd7:    f_seg = 7'b1111000;
            4'd8:    f_seg = 7'b0000000;
            4'd9:    f_seg = 7'b0011000;
            default: f_seg = SegBlank;
        endcase
    endfunction

    // Binary guess (0..31) split into decimal tens and ones
    logic [3:0] w_g_tens;
    logic [3:0] w_g_ones;

    always_comb begin
        w_g_tens = 4'd0;
        w_g_ones = 4'(w_guess);
        if (w_guess >= 5'd30) begin
            w_g_tens = 4'd3;
            w_g_ones = 4'(w_guess - 5'd30);
        end else if (w_guess >= 5'd20) begin
            w_g_tens = 4'd2;
            w_g_ones = 4'(w_guess - 5'd20);
        end else if (w_guess >= 5'd10) begin
            w_g_tens = 4'd1;
            w_g_ones = 4'(w_guess - 5'd10);
        end
    end

    // Display decode per state, combinational from registers
    always_comb begin
        o_seg0 = f_seg(w_g_ones);
        o_seg1 = f_seg(w_g_tens);
        o_seg2 = f_seg(r_att);
        o_seg3 = f_seg(4'd0);
        o_seg4 = f_seg(r_sec[3:0]);
        o_seg5 = f_seg(r_sec[7:4]);
        case (r_state)
            StIdle: begin
                o_seg0 = SegBlank;
                o_seg1 = SegBlank;
                o_seg2 = f_seg(4'd0);
                o_seg4 = f_seg(4'd0);
                o_seg5 = f_seg(4'd0);
            end
            StCheat: begin
                o_seg0 = SegDash;
                o_seg1 = SegDash;
            end
            default: begin
            end
        endcase
    end

    assign o_done  = r_done;
    assign o_cheat = r_cheat;

endmodule
